serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 33 +++
 rtl/full_adder_cell.sv | 27 ++
 rtl/serial_adder.sv | 192 +++++++++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder.
//   state_t      - FSM states: IDLE, RUN, DONE
//   HACK_WORD_W  - default word width of the HACK datapath (16)
//   cnt_width()  - width of the bit counter for a given operand width
//
// Optional feature macro used by the adder: SERIAL_ADDER_SUB_EN
// (adds a 'sub' port and two's-complement subtraction).
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HACK_WORD_W = 16;

  // The counter only has to hold 0..w-1. Keep it at least one bit wide
  // so that the smallest legal width still gets a real register.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
//
// Single combinational 1-bit full adder. The serial adder pushes every
// bit pair of an operation through one instance of this cell.
//
// Ports:
//   x, y  in   operand bits
//   cin   in   carry into this bit
//   sum   out  x ^ y ^ cin
//   cout  out  carry out of this bit
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = x ^ y;
  assign sum      = half_sum ^ cin;
  assign cout     = (x & y) | (cin & half_sum);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A start pulse accepted in IDLE or DONE
// captures both operands and the carry-in; the block then processes one
// bit pair per cycle, LSB first, through a single full_adder_cell, with
// the carry held in a flip-flop between bits. After WIDTH cycles of RUN
// the result is published and done pulses for one cycle.
//
// Parameters:
//   WIDTH  operand/result width, legal range 2..32 (default HACK_WORD_W)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, only honoured in IDLE or DONE
//   a, b   in   operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   sub    in   subtract request (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the next completion
//   cout   out  carry out of bit WIDTH-1 (with sub: 1 means no borrow)
//   ovf    out  signed overflow
//
// Optional feature macro: SERIAL_ADDER_SUB_EN. When defined, sub=1 on an
// accepted start captures ~b and forces the carry to 1 (A-B = A+~B+1).
// When undefined the block is add-only and no inversion logic exists.
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Only WIDTH-1 bits are stored: the final bit comes straight from the
  // cell on the last cycle and goes directly into sum.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             c_msb;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand B and the initial carry as they are loaded on accept.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  full_adder_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit  = (cnt_q == LAST_BIT);
  // The carry FF currently holds the carry into the bit being processed,
  // so on the last bit it is exactly the carry into the MSB.
  assign c_msb     = carry_q;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = {fa_sum, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        done_d = 1'b0;
        if (accept) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift[WIDTH-1:1];
        carry_d = fa_cout;
        if (last_bit) begin
          // Counter is cleared instead of incremented so it never wraps.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = fa_cout;
          ovf_d   = c_msb ^ fa_cout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder at the default width of 16 bits.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high for one edge (E0).
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Observe the DUT for n cycles starting just after E0. Between k=hold_lo
  // and k=hold_hi start is driven high with operands pa/pb.
  task automatic observe(input int n, input int hold_lo, input int hold_hi,
                         input logic [W-1:0] pa, input logic [W-1:0] pb,
                         output int done_at0, output int done_at1,
                         output int done_count, output int busy_cycles,
                         output bit overlap, output bit early_change,
                         output bit mid_change, output bit busy_after_done,
                         output logic [W-1:0] sum0, output logic cout0,
                         output logic ovf0, output logic [W-1:0] sum1);
    logic [W-1:0] sum_start;
    done_at0 = -1; done_at1 = -1; done_count = 0; busy_cycles = 0;
    overlap = 0; early_change = 0; mid_change = 0; busy_after_done = 0;
    sum0 = '0; cout0 = 0; ovf0 = 0; sum1 = '0;
    sum_start = sum;
    for (int k = 0; k < n; k++) begin
      if (busy) busy_cycles++;
      if (busy && done) overlap = 1;
      if (done_count == 0 && !done && sum !== sum_start) early_change = 1;
      if (done_count == 1 && !done && sum !== sum0) mid_change = 1;
      if (done_at0 >= 0 && k == done_at0 + 1) busy_after_done = busy;
      if (done) begin
        if (done_count == 0) begin
          done_at0 = k; sum0 = sum; cout0 = cout; ovf0 = ovf;
        end else if (done_count == 1) begin
          done_at1 = k; sum1 = sum;
        end
        done_count++;
      end
      if (k >= hold_lo && k <= hold_hi) begin
        start = 1'b1; a = pa; b = pb;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; a = '0; b = '0; cin = 0; sub = 0;
    step(); step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_busy_done: got %b, expected 00", {busy, done});
    end
    n_checks++;
    if ({sum, cout, ovf} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_result: got sum=%h cout=%b ovf=%b, expected 0", sum, cout, ovf);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    issue(16'h0003, 16'h0004, 1'b0, 1'b0);
    observe(20, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if (d0 !== 16) begin n_fail++; $display("[TB] FAIL basic_done_time: got %0d, expected 16", d0); end
    n_checks++;
    if (bc !== 16) begin n_fail++; $display("[TB] FAIL basic_busy_cycles: got %0d, expected 16", bc); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("[TB] FAIL basic_done_count: got %0d, expected 1", dc); end
    n_checks++;
    if ({s0, c0, o0} !== {16'h0007, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL basic_result: got sum=%h cout=%b ovf=%b, expected 0007 0 0", s0, c0, o0);
    end
    n_checks++;
    if (ov !== 0 || ec !== 0) begin
      n_fail++; $display("[TB] FAIL basic_flags: got overlap=%b early_change=%b, expected 0 0", ov, ec);
    end
  endtask

  task automatic test_carry_overflow();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    observe(18, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if ({s0, c0, o0} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL wrap_result: got sum=%h cout=%b ovf=%b, expected 0000 1 0", s0, c0, o0);
    end
    n_checks++;
    if (ec !== 0) begin n_fail++; $display("[TB] FAIL wrap_hold: got early_change=%b, expected 0", ec); end
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    observe(18, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if ({s0, c0, o0} !== {16'h8000, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL ovf_result: got sum=%h cout=%b ovf=%b, expected 8000 0 1", s0, c0, o0);
    end
    issue(16'h1234, 16'h1111, 1'b1, 1'b0);
    observe(18, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if ({s0, c0, o0} !== {16'h2346, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL cin_result: got sum=%h cout=%b ovf=%b, expected 2346 0 0", s0, c0, o0);
    end
    n_checks++;
    if (ec !== 0) begin n_fail++; $display("[TB] FAIL cin_hold: got early_change=%b, expected 0", ec); end
  endtask

  task automatic test_ignore_start();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    issue(16'h0010, 16'h0020, 1'b0, 1'b0);
    observe(20, 3, 10, 16'hFFFF, 16'hFFFF, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if (s0 !== 16'h0030 || c0 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ignore_result: got sum=%h cout=%b, expected 0030 0", s0, c0);
    end
    n_checks++;
    if (d0 !== 16 || dc !== 1) begin
      n_fail++; $display("[TB] FAIL ignore_done: got at=%0d count=%0d, expected 16 1", d0, dc);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    int seen_done;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                         busy, done, sum, cout, ovf);
    end
    step(); step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) seen_done++;
      step();
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++; $display("[TB] FAIL midreset_no_done: got %0d active cycles, expected 0", seen_done);
    end
    issue(16'h0102, 16'h0304, 1'b0, 1'b0);
    observe(20, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if (s0 !== 16'h0406 || d0 !== 16) begin
      n_fail++; $display("[TB] FAIL midreset_recover: got sum=%h at=%0d, expected 0406 16", s0, d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    issue(16'h0100, 16'h0001, 1'b0, 1'b0);
    // start held from mid-RUN through DONE; second operands are used.
    observe(40, 5, 16, 16'h0200, 16'h0002, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if (d0 !== 16 || d1 !== 33 || dc !== 2) begin
      n_fail++; $display("[TB] FAIL b2b_done_times: got %0d %0d count=%0d, expected 16 33 2", d0, d1, dc);
    end
    n_checks++;
    if (s0 !== 16'h0101 || s1 !== 16'h0202) begin
      n_fail++; $display("[TB] FAIL b2b_results: got %h %h, expected 0101 0202", s0, s1);
    end
    n_checks++;
    if (mc !== 0) begin n_fail++; $display("[TB] FAIL b2b_hold: got mid_change=%b, expected 0", mc); end
    n_checks++;
    if (bad !== 1 || ov !== 0) begin
      n_fail++; $display("[TB] FAIL b2b_handover: got busy_after_done=%b overlap=%b, expected 1 0", bad, ov);
    end
    n_checks++;
    if (bc !== 32) begin n_fail++; $display("[TB] FAIL b2b_busy_cycles: got %0d, expected 32", bc); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_subtract();
    int d0, d1, dc, bc; bit ov, ec, mc, bad;
    logic [W-1:0] s0, s1; logic c0, o0;
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    observe(18, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if ({s0, c0, o0} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL sub_borrow: got sum=%h cout=%b ovf=%b, expected FFFE 0 0", s0, c0, o0);
    end
    // cin is ignored while subtracting.
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    observe(18, -1, -1, '0, '0, d0, d1, dc, bc, ov, ec, mc, bad, s0, c0, o0, s1);
    n_checks++;
    if ({s0, c0, o0} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL sub_ovf: got sum=%h cout=%b ovf=%b, expected 7FFF 1 1", s0, c0, o0);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_carry_overflow();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
